// File: rtl/up_dn_counter_pkg.sv
// Shared types for the parametrised up/down counter: operation encoding and mode constants.
package up_dn_counter_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } cnt_op_e;

  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

endpackage

// File: rtl/up_dn_next_calc.sv
// Combinational next-count calculation with boundary events for one counter operation.
module up_dn_next_calc
  import up_dn_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 31
) (
  input  cnt_op_e          op,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH:0]   step_eff,
  input  logic             wrap_mode,
  output logic [WIDTH-1:0] nxt,
  output logic             ovf_ev,
  output logic             unf_ev,
  output logic             wrap_ev,
  output logic             clamp_ev
);

  // Two guard bits: one for carry past 2**WIDTH, one for sign on decrement.
  localparam int unsigned XW = WIDTH + 2;
  localparam logic signed [XW-1:0] MIN_X   = XW'(MIN_VAL);
  localparam logic signed [XW-1:0] MAX_X   = XW'(MAX_VAL);
  localparam logic signed [XW-1:0] RANGE_X = XW'(MAX_VAL - MIN_VAL + 1);

  logic signed [XW-1:0] cnt_x;
  logic signed [XW-1:0] step_x;
  logic signed [XW-1:0] ld_x;
  logic signed [XW-1:0] sum_x;
  logic signed [XW-1:0] diff_x;

  always_comb begin
    cnt_x    = signed'({2'b00, cnt});
    step_x   = signed'({1'b0, step_eff});
    ld_x     = signed'({2'b00, load_val});
    sum_x    = cnt_x + step_x;
    diff_x   = cnt_x - step_x;
    nxt      = cnt;
    ovf_ev   = 1'b0;
    unf_ev   = 1'b0;
    wrap_ev  = 1'b0;
    clamp_ev = 1'b0;
    case (op)
      OP_LOAD: begin
        if (ld_x > MAX_X) begin
          nxt      = WIDTH'(MAX_VAL);
          clamp_ev = 1'b1;
        end else if (ld_x < MIN_X) begin
          nxt      = WIDTH'(MIN_VAL);
          clamp_ev = 1'b1;
        end else begin
          nxt = load_val;
        end
      end
      OP_INC: begin
        if (sum_x <= MAX_X) begin
          nxt = WIDTH'(sum_x);
        end else begin
          ovf_ev = 1'b1;
          if (wrap_mode == MODE_WRAP) begin
            nxt     = WIDTH'(sum_x - RANGE_X);
            wrap_ev = 1'b1;
          end else begin
            nxt = WIDTH'(MAX_VAL);
          end
        end
      end
      OP_DEC: begin
        if (diff_x >= MIN_X) begin
          nxt = WIDTH'(diff_x);
        end else begin
          unf_ev = 1'b1;
          if (wrap_mode == MODE_WRAP) begin
            nxt     = WIDTH'(diff_x + RANGE_X);
            wrap_ev = 1'b1;
          end else begin
            nxt = WIDTH'(MIN_VAL);
          end
        end
      end
      default: nxt = cnt;
    endcase
  end

endmodule

// File: rtl/up_dn_counter_param.sv
// Bounded loadable up/down counter with saturate/wrap mode, sticky ovf/unf and event pulses.
module up_dn_counter_param
  import up_dn_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = (32'd1 << WIDTH) - 32'd1,
  parameter int unsigned STEP_W  = WIDTH
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              UP,
  input  logic              DOWN,
  input  logic [STEP_W-1:0] step,
  input  logic              wrap_mode,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  Counter,
  output logic              High,
  output logic              Low,
  output logic              ovf,
  output logic              unf,
  output logic              wrap_p,
  output logic              load_err
);

  localparam int unsigned RANGE = MAX_VAL - MIN_VAL + 1;

  if (MIN_VAL >= MAX_VAL || 64'(MAX_VAL) >= (64'd1 << WIDTH)) begin : g_bad_bounds
    $error("up_dn_counter_param: need MIN_VAL < MAX_VAL < 2**WIDTH");
  end

  cnt_op_e          op;
  logic [WIDTH:0]   step_eff;
  logic [WIDTH-1:0] counter_d, counter_q;
  logic             ovf_d, ovf_q;
  logic             unf_d, unf_q;
  logic             wrap_p_d, wrap_p_q;
  logic             load_err_d, load_err_q;
  logic [WIDTH-1:0] nxt;
  logic             ovf_ev, unf_ev, wrap_ev, clamp_ev;

  // Priority decode (DOWN beats UP) and step clamp to one full range.
  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en && DOWN) begin
      op = OP_DEC;
    end else if (en && UP) begin
      op = OP_INC;
    end
    if (32'(step) > RANGE) begin
      step_eff = (WIDTH+1)'(RANGE);
    end else begin
      step_eff = (WIDTH+1)'(step);
    end
  end

  up_dn_next_calc #(
    .WIDTH   (WIDTH),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_next_calc (
    .op        (op),
    .cnt       (counter_q),
    .load_val  (load_val),
    .step_eff  (step_eff),
    .wrap_mode (wrap_mode),
    .nxt       (nxt),
    .ovf_ev    (ovf_ev),
    .unf_ev    (unf_ev),
    .wrap_ev   (wrap_ev),
    .clamp_ev  (clamp_ev)
  );

  // Sticky flags: a new event in the clearing cycle keeps the flag set.
  always_comb begin
    counter_d  = nxt;
    ovf_d      = (ovf_q & ~clr_flags) | ovf_ev;
    unf_d      = (unf_q & ~clr_flags) | unf_ev;
    wrap_p_d   = wrap_ev;
    load_err_d = clamp_ev;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      counter_q  <= WIDTH'(MIN_VAL);
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      wrap_p_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      counter_q  <= counter_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      wrap_p_q   <= wrap_p_d;
      load_err_q <= load_err_d;
    end
  end

  assign Counter  = counter_q;
  assign High     = (counter_q == WIDTH'(MAX_VAL));
  assign Low      = (counter_q == WIDTH'(MIN_VAL));
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign wrap_p   = wrap_p_q;
  assign load_err = load_err_q;

endmodule
